// File: rtl/softmax_max_sub_ctrl_pkg.sv
// Shared defaults and FSM encodings for the softmax max-subtract row sequencer.
package softmax_max_sub_ctrl_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ROW_LEN_DEF    = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SUB  = 2'd2;

endpackage

// File: rtl/softmax_max_sub_ctrl_sub.sv
// Shared subtractor: a - b when enabled, zero otherwise so idle cycles do not toggle the output.
module softmax_max_sub_ctrl_sub #(
    parameter int unsigned W = 9
) (
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff_c
);

    // Gated difference
    always_comb begin
        diff_c = '0;
        if (en) begin
            diff_c = a - b;
        end
    end

endmodule

// File: rtl/softmax_max_sub_ctrl.sv
// Row sequencer for softmax stabilisation: buffers one row of signed scores while
// tracking the maximum, then streams out saturated (x_i - max) through one subtractor.
module softmax_max_sub_ctrl
    import softmax_max_sub_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ROW_LEN    = ROW_LEN_DEF,
    parameter int unsigned LEN_W      = $clog2(ROW_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] row_max,
    output logic                  busy
);

    localparam int unsigned      IDX_W   = $clog2(ROW_LEN);
    localparam int unsigned      SUB_W   = DATA_WIDTH + 1;
    localparam logic [SUB_W-1:0] SAT_MIN = {2'b11, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [SUB_W-1:0] SAT_MAX = {2'b00, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(ROW_LEN);

    logic [1:0]            state_q,     state_d;
    logic [LEN_W-1:0]      wr_cnt_q,    wr_cnt_d;
    logic [LEN_W-1:0]      rd_ptr_q,    rd_ptr_d;
    logic [LEN_W-1:0]      len_q,       len_d;
    logic [DATA_WIDTH-1:0] max_q,       max_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  out_last_q,  out_last_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  busy_q,      busy_d;

    logic [DATA_WIDTH-1:0] row_buf_q [ROW_LEN];
    logic                  buf_we_c;
    logic [IDX_W-1:0]      buf_waddr_c;

    logic [LEN_W-1:0]      len_res_c;
    logic                  accept_c;
    logic                  out_load_c;
    logic                  last_rd_c;
    logic [DATA_WIDTH-1:0] rd_data_c;
    logic [SUB_W-1:0]      diff_c;
    logic [DATA_WIDTH-1:0] sat_c;

    assign len_res_c  = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    assign accept_c   = in_valid && in_ready_q;
    assign out_load_c = !out_valid_q || out_ready;
    assign rd_data_c  = row_buf_q[IDX_W'(rd_ptr_q)];
    assign last_rd_c  = (rd_ptr_q == len_q - LEN_W'(1));

    softmax_max_sub_ctrl_sub #(
        .W (SUB_W)
    ) u_sub (
        .en     (state_q == ST_SUB),
        .a      ({rd_data_c[DATA_WIDTH-1], rd_data_c}),
        .b      ({max_q[DATA_WIDTH-1], max_q}),
        .diff_c (diff_c)
    );

    // Clamp the widened difference back to the element range
    always_comb begin
        sat_c = diff_c[DATA_WIDTH-1:0];
        if ($signed(diff_c) < $signed(SAT_MIN)) begin
            sat_c = SAT_MIN[DATA_WIDTH-1:0];
        end else if ($signed(diff_c) > $signed(SAT_MAX)) begin
            sat_c = SAT_MAX[DATA_WIDTH-1:0];
        end
    end

    // Next-state, buffer write and output register logic
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        max_d       = max_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        buf_we_c    = 1'b0;
        buf_waddr_c = '0;

        // Outside SUB the output register only drains
        if (state_q != ST_SUB && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    buf_we_c = 1'b1;
                    max_d    = in_data;
                    len_d    = len_res_c;
                    wr_cnt_d = LEN_W'(1);
                    rd_ptr_d = '0;
                    state_d  = (len_res_c == LEN_W'(1)) ? ST_SUB : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept_c) begin
                    buf_we_c    = 1'b1;
                    buf_waddr_c = IDX_W'(wr_cnt_q);
                    wr_cnt_d    = wr_cnt_q + LEN_W'(1);
                    // Strict compare so ties keep the existing maximum
                    if ($signed(in_data) > $signed(max_q)) begin
                        max_d = in_data;
                    end
                    if (wr_cnt_q == len_q - LEN_W'(1)) begin
                        state_d  = ST_SUB;
                        rd_ptr_d = '0;
                    end
                end
            end
            ST_SUB: begin
                if (out_load_c) begin
                    out_data_d  = sat_c;
                    out_last_d  = last_rd_c;
                    out_valid_d = 1'b1;
                    rd_ptr_d    = rd_ptr_q + LEN_W'(1);
                    if (last_rd_c) begin
                        state_d  = ST_IDLE;
                        rd_ptr_d = '0;
                        wr_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d != ST_SUB);
        busy_d     = (state_d != ST_IDLE);
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            max_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            len_q       <= len_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Row buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (buf_we_c) begin
            row_buf_q[buf_waddr_c] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign row_max   = max_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_softmax_max_sub_ctrl.sv
// Directed bench for the softmax max-subtract row sequencer.
module tb_softmax_max_sub_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] cfg_len;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [7:0] row_max;
    logic       busy;

    int checks;
    int errors;

    softmax_max_sub_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .row_max   (row_max),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one element and hold it until accepted (bounded)
    task automatic push(input logic [7:0] v);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && g < 64) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cfg_len = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got=%0h exp=0", out_data); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL rst_out_last got=%0b exp=0", out_last); end
        checks++; if (row_max !== 8'h00)  begin errors++; $display("FAIL rst_row_max got=%0h exp=0", row_max); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL idle_in_ready got=%0b exp=1", in_ready); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL idle_busy got=%0b exp=0", busy); end
    endtask

    // Table of rows with full-throughput drain, latency and in_ready checks
    task automatic test_rows();
        int n, k, cyc, emax;
        logic [4:0] len;
        int v [16];
        int e [16];
        out_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            case (r)
                0: begin n = 4; len = 5'd4; emax = 7;
                         v[0] = 3; v[1] = -5; v[2] = 7; v[3] = 0;
                         e[0] = -4; e[1] = -12; e[2] = 0; e[3] = -7; end
                1: begin n = 2; len = 5'd2; emax = 127;
                         v[0] = -128; v[1] = 127; e[0] = -128; e[1] = 0; end
                2: begin n = 1; len = 5'd1; emax = 42; v[0] = 42; e[0] = 0; end
                3: begin n = 16; len = 5'd0; emax = 15;
                         for (int i = 0; i < 16; i++) begin v[i] = i; e[i] = i - 15; end end
                4: begin n = 16; len = 5'd31; emax = 15;
                         for (int i = 0; i < 16; i++) begin v[i] = 15 - i; e[i] = -i; end end
                default: begin n = 3; len = 5'd3; emax = -3;
                         v[0] = -3; v[1] = -3; v[2] = -7; e[0] = 0; e[1] = 0; e[2] = -4; end
            endcase
            cfg_len = len;
            for (int i = 0; i < n; i++) begin
                push(8'(v[i]));
                cfg_len = 5'd9;
            end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL row%0d_latency out_valid=%0b exp=0", r, out_valid); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL row%0d_sub_in_ready got=%0b exp=0", r, in_ready); end
            checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL row%0d_busy got=%0b exp=1", r, busy); end
            checks++; if (row_max !== 8'(emax)) begin errors++; $display("FAIL row%0d_row_max got=%0d exp=%0d", r, $signed(row_max), emax); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL row%0d_first_valid got=%0b exp=1", r, out_valid); end
            k = 0; cyc = 0;
            while (k < n && cyc < 64) begin
                if (out_valid) begin
                    checks++;
                    if (out_data !== 8'(e[k]) || out_last !== (k == n - 1)) begin
                        errors++;
                        $display("FAIL row%0d_out[%0d] got=%0d/last%0b exp=%0d/last%0b", r, k, $signed(out_data), out_last, e[k], (k == n - 1));
                    end
                    if (!out_last) begin
                        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL row%0d_in_ready_sub[%0d] got=%0b exp=0", r, k, in_ready); end
                    end
                    k++;
                end
                @(posedge clk); #1;
                cyc++;
            end
            checks++; if (k != n) begin errors++; $display("FAIL row%0d_count got=%0d exp=%0d", r, k, n); end
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL row%0d_drain out_valid=%0b in_ready=%0b exp=0/1", r, out_valid, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        int x;
        logic stalled;
        logic [7:0] pdata;
        logic plast;
        int e [3];
        e[0] = -2; e[1] = -1; e[2] = 0;
        out_ready = 1'b1;
        cfg_len = 5'd3;
        push(8'd1); push(8'd2); push(8'd3);
        x = 0; stalled = 1'b0; pdata = '0; plast = 1'b0;
        for (int c = 0; c < 30; c++) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pdata || out_last !== plast) begin
                    errors++;
                    $display("FAIL bp_hold c=%0d got=%0b/%0d/%0b exp=1/%0d/%0b", c, out_valid, $signed(out_data), out_last, $signed(pdata), plast);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (x > 2) begin
                    errors++; $display("FAIL bp_extra got=%0d transfers exp=3", x + 1);
                end else if (out_data !== 8'(e[x]) || out_last !== (x == 2)) begin
                    errors++;
                    $display("FAIL bp_out[%0d] got=%0d/last%0b exp=%0d/last%0b", x, $signed(out_data), out_last, e[x], (x == 2));
                end
                x++;
            end
            stalled = out_valid && !out_ready;
            pdata = out_data;
            plast = out_last;
            @(posedge clk); #1;
        end
        checks++; if (x != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", x); end
        out_ready = 1'b1;
    endtask

    task automatic test_overlap();
        int k, cyc;
        int e [3];
        logic l [3];
        e[0] = 0; e[1] = 0; e[2] = -3;
        l[0] = 1'b1; l[1] = 1'b0; l[2] = 1'b1;
        out_ready = 1'b0;
        cfg_len = 5'd1;
        push(8'd9);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_last !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL ov_pending got=%0b/%0b/%0b exp=1/1/1", out_valid, out_last, in_ready); end
        cfg_len = 5'd2;
        push(8'hFF);
        checks++; if (row_max !== 8'hFF) begin errors++; $display("FAIL ov_row_max got=%0d exp=-1", $signed(row_max)); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h00 || out_last !== 1'b1) begin errors++; $display("FAIL ov_hold got=%0b/%0d/%0b exp=1/0/1", out_valid, $signed(out_data), out_last); end
        push(8'hFC);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ov_sub_in_ready got=%0b exp=0", in_ready); end
        out_ready = 1'b1;
        k = 0; cyc = 0;
        while (k < 3 && cyc < 32) begin
            if (out_valid) begin
                checks++;
                if (out_data !== 8'(e[k]) || out_last !== l[k]) begin
                    errors++;
                    $display("FAIL ov_out[%0d] got=%0d/last%0b exp=%0d/last%0b", k, $signed(out_data), out_last, e[k], l[k]);
                end
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (k != 3 || out_valid !== 1'b0) begin errors++; $display("FAIL ov_count got=%0d valid=%0b exp=3/0", k, out_valid); end
    endtask

    task automatic test_reset_mid();
        int k, cyc;
        int e [4];
        e[0] = -30; e[1] = -20; e[2] = -10; e[3] = 0;
        out_ready = 1'b1;
        cfg_len = 5'd4;
        push(8'd10); push(8'd20); push(8'd30); push(8'd40);
        k = 0; cyc = 0;
        while (k < 2 && cyc < 32) begin
            if (out_valid) begin
                checks++;
                if (out_data !== 8'(e[k]) || out_last !== 1'b0) begin
                    errors++; $display("FAIL rm_out[%0d] got=%0d/last%0b exp=%0d/last0", k, $signed(out_data), out_last, e[k]);
                end
                k++;
            end
            if (k < 2) begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL rm_async got=%0b/%0b exp=0/0", out_valid, out_last); end
        checks++; if (busy !== 1'b0 || row_max !== 8'h00 || in_ready !== 1'b0) begin errors++; $display("FAIL rm_state busy=%0b max=%0h rdy=%0b exp=0/0/0", busy, row_max, in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_idle rdy=%0b valid=%0b exp=1/0", in_ready, out_valid); end
        cfg_len = 5'd2;
        push(8'd5); push(8'd5);
        k = 0; cyc = 0;
        while (k < 3 && cyc < 16) begin
            if (out_valid) begin
                checks++;
                if (k > 1) begin
                    errors++; $display("FAIL rm_extra got=%0d outputs exp=2", k + 1);
                end else if (out_data !== 8'h00 || out_last !== (k == 1)) begin
                    errors++; $display("FAIL rm_new[%0d] got=%0d/last%0b exp=0/last%0b", k, $signed(out_data), out_last, (k == 1));
                end
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (k != 2) begin errors++; $display("FAIL rm_new_count got=%0d exp=2", k); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rows();
        test_backpressure();
        test_overlap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
